// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants and fetch FSM state type
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register: flush beats stall beats load, else bubble
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          W   = XLEN,
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [31:0]  fetch_instr,
  input  logic [W-1:0] fetch_pc,
  input  logic [W-1:0] fetch_pc_plus4,
  output logic [31:0]  instr,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr    <= fetch_instr;
        pc       <= fetch_pc;
        pc_plus4 <= fetch_pc_plus4;
        valid    <= 1'b1;
      end else begin
        instr    <= NOP;
        pc       <= '0;
        pc_plus4 <= '0;
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch: PC register, redirect handling over a
// variable-latency instruction memory, and the IF/ID register
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN_P    = XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_VALUE = NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN_P-1:0] PCTargetE,
  output logic              imem_req,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [XLEN_P-1:0] PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN_P-1:0] PCD,
  output logic [XLEN_P-1:0] PCPlus4D,
  output logic              ValidD
);

  fetch_state_t      state;
  logic [XLEN_P-1:0] pend_target;
  logic [XLEN_P-1:0] pc_plus4;
  logic              done;
  logic              load;

  assign imem_req  = !reset;
  assign imem_addr = PCF;
  assign done      = imem_req && imem_ready;
  assign pc_plus4  = PCF + XLEN_P'(4);
  assign load      = (state == FETCH) && done && !StallF;

  // PCF only moves on a completed handshake, keeping imem_addr stable while waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF         <= RESET_PC;
      state       <= FETCH;
      pend_target <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (PCSrcE) begin
            if (done) begin
              PCF <= PCTargetE;
            end else begin
              pend_target <= PCTargetE;
              state       <= DRAIN;
            end
          end else if (done && !StallF) begin
            PCF <= pc_plus4;
          end
        end
        DRAIN: begin
          if (done) begin
            PCF   <= PCSrcE ? PCTargetE : pend_target;
            state <= FETCH;
          end else if (PCSrcE) begin
            pend_target <= PCTargetE;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .W   (XLEN_P),
    .NOP (NOP_VALUE)
  ) u_if_id (
    .clk            (clk),
    .reset          (reset),
    .flush          (FlushD || PCSrcE),
    .stall          (StallD),
    .load           (load),
    .fetch_instr    (imem_rdata),
    .fetch_pc       (PCF),
    .fetch_pc_plus4 (pc_plus4),
    .instr          (InstrD),
    .pc             (PCD),
    .pc_plus4       (PCPlus4D),
    .valid          (ValidD)
  );

endmodule
